reload_fifo_reader: RTL

- Read-side master for reload_fifo. It drains a programmed number of words from the FIFO and presents them on a valid/ready stream to the downstream consumer, flagging the final word.
- It hides the FIFO's one-cycle registered read latency using a 2-entry output buffer with credit-based pop issue.
- It sits between reload_fifo and the reload consumer; a control FSM sequences it with start/count and observes done.

---
 rtl/reload_pkg.sv | 27 ++
 rtl/reload_skid_buf.sv | 79 +++++++
 rtl/reload_fifo_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reload_pkg.sv
// Shared types and defaults for the reload FIFO read path.
package reload_pkg;

  localparam int FIFO_WIDTH_DEF     = 32;
  localparam int CNT_WIDTH_DEF      = 16;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

  // A word leaving the buffer this cycle frees its slot for the pop issued now,
  // which is what lets the stream sustain one word per cycle.
  function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic rd);
    logic [2:0] used;
    used = {1'b0, occ} + {2'b00, inflight};
    if (rd) begin
      used = used - 3'd1;
    end else begin
      used = used;
    end
    return (used < 3'd2);
  endfunction

endpackage

// File: rtl/reload_skid_buf.sv
// Two-entry output buffer for the reload reader: occupancy tracking, valid/ready head.
module reload_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             rd_fire_s;

  assign rd_fire_s = (occ_q != 2'd0) && rd_ready_i;

  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (wr_en_i) begin
        if (wr_ptr_q) begin
          ent1_d = wr_data_i;
        end else begin
          ent0_d = wr_data_i;
        end
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_fire_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_i, rd_fire_s})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0_q   <= {WIDTH{1'b0}};
      ent1_q   <= {WIDTH{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Writes always target the non-head slot, so the head is stable while stalled.
  assign rd_valid_o = (occ_q != 2'd0);
  assign rd_data_o  = rd_ptr_q ? ent1_q : ent0_q;
  assign occ_o      = occ_q;

endmodule

// File: rtl/reload_fifo_reader.sv
// Read-side master for reload_fifo: drains a programmed word count onto a valid/ready stream.
// Optional empty-stall watchdog and timeout_err port are built when RELOAD_RD_TIMEOUT_EN is defined.
module reload_fifo_reader
  import reload_pkg::*;
#(
  parameter int FIFO_WIDTH     = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rden,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  input  logic                  fifo_empty,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
`ifdef RELOAD_RD_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  rd_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  pop_left_q, pop_left_d;
  logic [CNT_WIDTH-1:0]  out_left_q, out_left_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_s;
  logic                  buf_valid_s;
  logic [FIFO_WIDTH-1:0] buf_data_s;
  logic                  abort_s, pop_s, beat_s, wr_en_s, start_ok_s;

  assign beat_s     = buf_valid_s && m_ready;
  assign start_ok_s = (state_q == ST_IDLE) && start && !abort_s;
  assign pop_s      = (state_q == ST_RUN) && !fifo_empty && (pop_left_q != CNT_ZERO)
                      && credit_ok(occ_s, inflight_q, beat_s) && !abort_s;
  // An inflight word landing in the abort cycle is dropped, not returned to the FIFO.
  assign wr_en_s    = inflight_q && !abort_s;
  assign inflight_d = pop_s;

`ifdef RELOAD_RD_TIMEOUT_EN
  localparam int             TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ZERO  = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] stall_q, stall_d;
  logic            timeout_err_q, timeout_err_d;
  logic            timeout_hit_s;

  assign timeout_hit_s = (state_q == ST_RUN) && (stall_q == TO_LIMIT);
  assign abort_s       = abort || timeout_hit_s;
  assign timeout_err   = timeout_err_q;

  always_comb begin
    stall_d       = stall_q;
    timeout_err_d = timeout_err_q;
    if (start_ok_s) begin
      stall_d       = TO_ZERO;
      timeout_err_d = 1'b0;
    end else if ((state_q != ST_RUN) || pop_s) begin
      stall_d       = TO_ZERO;
      timeout_err_d = timeout_err_q;
    end else if (fifo_empty && (pop_left_q != CNT_ZERO) && (stall_q != TO_LIMIT)) begin
      stall_d = stall_q + TO_ONE;
      if (stall_q == (TO_LIMIT - TO_ONE)) begin
        timeout_err_d = 1'b1;
      end else begin
        timeout_err_d = timeout_err_q;
      end
    end else begin
      stall_d       = stall_q;
      timeout_err_d = timeout_err_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q       <= TO_ZERO;
      timeout_err_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign abort_s = abort;
`endif

  always_comb begin
    state_d    = state_q;
    pop_left_d = pop_left_q;
    out_left_d = out_left_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          pop_left_d = count;
          out_left_d = count;
          if (count == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_d = ST_DONE;
        end else begin
          if (pop_s) begin
            pop_left_d = pop_left_q - CNT_ONE;
          end else begin
            pop_left_d = pop_left_q;
          end
          if (beat_s && (out_left_q != CNT_ZERO)) begin
            out_left_d = out_left_q - CNT_ONE;
            if (out_left_q == CNT_ONE) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            out_left_d = out_left_q;
            state_d    = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        pop_left_d = CNT_ZERO;
        out_left_d = CNT_ZERO;
      end
      default: begin
        state_d    = ST_IDLE;
        pop_left_d = CNT_ZERO;
        out_left_d = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pop_left_q <= CNT_ZERO;
      out_left_q <= CNT_ZERO;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_left_q <= pop_left_d;
      out_left_q <= out_left_d;
      inflight_q <= inflight_d;
    end
  end

  reload_skid_buf #(
    .WIDTH(FIFO_WIDTH)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (abort_s),
    .wr_en_i    (wr_en_s),
    .wr_data_i  (fifo_rddata),
    .rd_ready_i (m_ready),
    .rd_valid_o (buf_valid_s),
    .rd_data_o  (buf_data_s),
    .occ_o      (occ_s)
  );

  assign fifo_rden = pop_s;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign m_valid   = buf_valid_s;
  assign m_data    = buf_data_s;
  assign m_last    = buf_valid_s && (out_left_q == CNT_ONE);

endmodule
